// File: rtl/truth_table_checker.sv
// Self-test engine: walks every input vector through a small combinational DUT
// and compares its response against EXPECTED. Optional TRUTH_TABLE_CHECKER_SYNC_EN
// adds a 2-flop synchronizer on dut_out for DUTs sitting on external pins.
module truth_table_checker #(
    parameter int                        N_IN          = 2,
    parameter logic [(1 << N_IN) - 1:0]  EXPECTED      = 4'b1000,
    parameter int                        SETTLE_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic [N_IN-1:0]            dut_in,
    input  logic                       dut_out,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [N_IN:0]              err_count,
    output logic [(1 << N_IN) - 1:0]   fail_vec
);

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] IDX_MAX = {N_IN{1'b1}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (N_IN < 1 || N_IN > 4) begin : g_bad_n_in
            $error("truth_table_checker: N_IN must be in 1..4");
        end
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535) begin : g_bad_settle
            $error("truth_table_checker: SETTLE_CYCLES must be in 1..65535");
        end
    endgenerate

    // Holds at the all-ones value instead of wrapping.
    function automatic logic [N_IN:0] sat_inc(input logic [N_IN:0] v);
        if (v == {(N_IN + 1){1'b1}})
            return v;
        return v + 1'b1;
    endfunction

    logic [1:0]       state;
    logic [N_IN-1:0]  idx;
    logic [CNT_W-1:0] cnt;
    logic             cmp_val;
    logic             mismatch;
    logic             last_vec;
    logic [N_IN:0]    err_next;

`ifdef TRUTH_TABLE_CHECKER_SYNC_EN
    generate
        if (SETTLE_CYCLES < 3) begin : g_bad_sync_settle
            $error("truth_table_checker: SETTLE_CYCLES must be >= 3 with the synchronizer enabled");
        end
    endgenerate

    logic dut_out_p0;
    logic dut_out_p1;

    // Stage p0 -> p1: two-flop synchronizer; the compare sees dut_out two cycles late.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dut_out_p0 <= 1'b0;
            dut_out_p1 <= 1'b0;
        end else begin
            dut_out_p0 <= dut_out;
            dut_out_p1 <= dut_out_p0;
        end
    end

    assign cmp_val = dut_out_p1;
`else
    assign cmp_val = dut_out;
`endif

    always_comb begin
        mismatch = (cmp_val != EXPECTED[idx]);
        last_vec = (idx == IDX_MAX);
        err_next = mismatch ? sat_inc(err_count) : err_count;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            cnt       <= '0;
            dut_in    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_RUN;
                        idx       <= '0;
                        cnt       <= RELOAD;
                        dut_in    <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_vec  <= '0;
                    end
                end
                S_RUN: begin
                    if (cnt == '0) begin
                        // Sample point for the current vector.
                        if (mismatch) begin
                            fail_vec[idx] <= 1'b1;
                        end
                        err_count <= err_next;
                        if (!last_vec) begin
                            idx    <= idx + 1'b1;
                            dut_in <= idx + 1'b1;
                            cnt    <= RELOAD;
                        end else begin
                            state  <= S_DONE;
                            idx    <= '0;
                            dut_in <= '0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            pass   <= (err_next == '0);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    pass   <= 1'b0;
                    dut_in <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- On-board self-test engine for small combinational DUTs (gates, muxes) on the EDU-CIAA-FPGA.
- Drives every input vector 0..2^N_IN-1 onto the DUT in order, waits a settle time, samples the DUT output and compares it against a parameterised expected truth table.
- Reports per-vector failures, an error count and pass/fail, suitable for LEDs.
- It is the hardware checking end of the stimulus/response flow the simulation benches perform with `$display`/`$finish`.

Parameters:
- N_IN, 2, number of DUT inputs; legal range 1..4.
- EXPECTED, 4'b1000, expected truth table, width 2^N_IN; bit i is the expected dut_out for input vector i. The default is 2-input AND.
- SETTLE_CYCLES, 16, cycles each vector is held; legal range 1..65535.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- start  input  1  request a run; sampled only in IDLE or DONE
- dut_in  output  N_IN  stimulus vector to the DUT
- dut_out  input  1  DUT response
- busy  output  1  run in progress
- done  output  1  run finished; held until the next start or reset
- pass  output  1  1 when done=1 and err_count=0
- err_count  output  N_IN+1  number of mismatching vectors
- fail_vec  output  2^N_IN  bit i set if vector i mismatched

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled only on the rising edge of clk.
- Reset values: state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, vector index=0, settle counter=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Next cycle: state=RUN, busy=1, dut_in=0.
  - Settle counter loads SETTLE_CYCLES-1.
  - err_count and fail_vec are cleared.
- RUN:
  - dut_in equals the current index for exactly SETTLE_CYCLES cycles.
  - The counter decrements each cycle.
  - In the cycle where the counter is 0, the compare value is sampled and compared with EXPECTED[index].
  - On mismatch: fail_vec[index] is set and err_count increments, both visible the next cycle.
  - In that same cycle (counter=0), if index < 2^N_IN-1: index increments, dut_in updates, and the counter reloads SETTLE_CYCLES-1 for the next cycle.
  - Otherwise the next state is DONE.
- Run length: the first vector appears 1 cycle after start is accepted. Total busy time is exactly 2^N_IN × SETTLE_CYCLES cycles.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - dut_in returns to 0.
  - Results are held.
  - start=1 behaves as in IDLE: clears results and restarts. done drops in the same cycle busy rises.
- start while busy: ignored, with no restart and no effect on results.
- start held continuously: exactly one run per IDLE/DONE visit; the checker re-runs back-to-back with a 1-cycle DONE gap.
- SETTLE_CYCLES=1: each vector is held 1 cycle and sampled in that same cycle.
- err_count saturation: cannot overflow, since its width is N_IN+1 and the maximum value is 2^N_IN.
- rst_n low mid-run:
  - All outputs return to reset values on the next edge.
  - A partial result is never presented as done.
- pass is 0 whenever done=0.

Optional Feature:
- Macro: TRUTH_TABLE_CHECKER_SYNC_EN.
- Defined:
  - dut_out passes through a 2-flop synchronizer (reset to 0), and the compare uses the synchronized value.
  - Sampling still occurs at counter=0, so the effective DUT settle time is SETTLE_CYCLES-2.
  - SETTLE_CYCLES < 3 is an elaboration error.
  - Intended for DUTs on external pins.
- Undefined:
  - The compare uses raw dut_out.
  - No extra flops; SETTLE_CYCLES ≥ 1 is legal.

Test Plan:
1. Default parameters, DUT = correct AND model, start pulse.
   - dut_in steps 0,1,2,3, each held 16 cycles.
   - busy is high for exactly 64 cycles.
   - Then done=1, pass=1, err_count=0, fail_vec=4'b0000.
2. DUT = OR gate, default EXPECTED.
   - Mismatches at vectors 1 and 2.
   - done=1, pass=0, err_count=2, fail_vec=4'b0110.
3. DUT stuck at 1.
   - err_count=3, fail_vec=4'b0111.
   - Then swap in the AND model and pulse start: previous results are cleared, and the run ends with pass=1, err_count=0.
4. rst_n low for 1 cycle at cycle 30 of a run; then start.
   - The cycle after reset shows all outputs 0.
   - The new run completes normally with pass=1 after 64 busy cycles.
5. start pulsed again at cycle 20 of a run.
   - Ignored: busy stays high, and the run ends at cycle 64 with the same results as scenario 1.
6. N_IN=3, EXPECTED=8'b1110_1000 (majority), SETTLE_CYCLES=4, TRUTH_TABLE_CHECKER_SYNC_EN defined, correct majority DUT.
   - 32 busy cycles, pass=1.
   - With SETTLE_CYCLES=2 under the macro, elaboration fails.
